prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Consumes the 1-bit pseudo-random stream from the upstream lfsr stage, qualified by its valid strobe.
- Self-synchronises to the sequence, declares lock, then counts received bits and bit errors.
- Used as the receive-side BER monitor of the test data path and as the loopback check for the lfsr generator.

Parameters:
- LFSR_LEN, 15, sequence order; width of the internal shift register.
- TAPS, 15'h6000, feedback tap mask (x^15+x^14+1); must equal the generator's polynomial.
- LOCK_CNT, 32, consecutive matching bits required to declare lock.
- WINDOW, 64, valid-bit length of the loss-of-lock observation window.
- UNLOCK_ERR, 16, mismatches within one window that force loss of lock.
- CNT_W, 32, width of the bit and error counters.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  i_data qualifier; the block does nothing on cycles where i_valid=0
- i_data  in  1  received PRBS bit
- o_locked  out  1  high while in LOCKED
- o_err  out  1  one-cycle pulse per mismatching valid bit while LOCKED
- o_bit_cnt  out  CNT_W  valid bits received while LOCKED; saturating
- o_err_cnt  out  CNT_W  mismatches while LOCKED; saturating

Behaviour:
- Reset: one clock, synchronous, active-high. Reset values:
  - o_locked=0, o_err=0, o_bit_cnt=0, o_err_cnt=0.
  - Shift register sr=0, all internal counters 0, state=SEARCH.
  - Reset asserted mid-operation behaves the same as reset from power-up.
- Per valid bit:
  - pred = XOR-reduce(sr & TAPS); match = (i_data == pred).
  - sr <= {sr[LFSR_LEN-2:0], i_data}. The shift occurs in every state.
- Zero guard: a valid bit with sr==0 and i_data==0 counts as a mismatch, so the block never locks to the all-zero state.
- All outputs are registered and update on the clock edge that samples the valid bit (latency 1). Nothing changes when i_valid=0.
- States:
  - SEARCH: fill counter counts valid bits. After LFSR_LEN valid bits, go to SYNC with the match counter at 0.
  - SYNC: a match increments the match counter; a mismatch clears it to 0. When a match brings the counter to LOCK_CNT, go to LOCKED; on that same edge clear o_bit_cnt, o_err_cnt and the window counters.
  - LOCKED:
    - Every valid bit increments o_bit_cnt.
    - A mismatch increments o_err_cnt and sets o_err=1 for one cycle.
    - Window counter counts valid bits from 0 to WINDOW-1 and accumulates mismatches. On the WINDOW-th valid bit (including that bit): if window mismatches >= UNLOCK_ERR, go to SEARCH (o_locked=0 next cycle, fill counter cleared); otherwise clear the window mismatch count. The window counter wraps to 0 either way.
- Counter rules:
  - Counters saturate at all-ones and do not wrap.
  - o_bit_cnt and o_err_cnt hold their values after loss of lock until the next lock acquisition.
- Single bit error in LOCKED: produces 1 + popcount(TAPS) mismatches (3 with the defaults). This is the self-synchronising property and the specified behaviour.

Optional Feature:
- Macro: PRBS_CHK_CLEAR_EN.
- Defined: adds port i_clear (in, 1). i_clear=1 synchronously zeroes o_bit_cnt, o_err_cnt and o_err on the next edge without changing state, sr or the window counters. If i_clear and a counted valid bit coincide, clear wins and that bit is not counted.
- Undefined: no i_clear port; counters clear only on reset and on lock acquisition.

Test Plan:
- Lock acquisition: feed the lfsr generator output (same TAPS), i_valid=1 continuously -> o_locked rises on the edge of valid bit 47 (15 fill + 32 matches); o_bit_cnt=0 at lock; o_bit_cnt=100 after 100 further bits; o_err_cnt=0.
- Gapped valid: i_valid toggling 1/0 every cycle -> lock after 47 valid bits (94 cycles); counters advance only on valid cycles; o_err never pulses.
- Single error: after lock, invert one bit -> exactly 3 o_err pulses, o_err_cnt=3, o_locked stays 1.
- Loss of lock: after lock, feed random data for 200 bits -> o_locked=0 by the end of the first or second 64-bit window; o_err_cnt frozen afterwards; relock within 47 valid bits once the clean PRBS resumes.
- All-zero input: i_data=0, i_valid=1 for 500 bits -> o_locked remains 0.
- Reset mid-lock: assert i_reset for 2 cycles while LOCKED -> all outputs 0 on the next edge; normal relock after 47 valid bits. With PRBS_CHK_CLEAR_EN: a 1-cycle i_clear pulse zeroes the counters and o_locked stays 1.

Source files
------------

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - self-synchronising PRBS checker with lock FSM and BER counters
//
// Purpose: takes the 1-bit PRBS stream from the lfsr stage and self-synchronises
// to it. It declares lock after LOCK_CNT consecutive matching bits. While locked
// it counts received bits and bit errors, and it drops lock when one WINDOW-bit
// observation window holds UNLOCK_ERR or more mismatches.
//
// Ports:
//   i_clk      in   1      clock
//   i_reset    in   1      synchronous, active-high reset
//   i_clear    in   1      counter clear (only when PRBS_CHK_CLEAR_EN is defined)
//   i_valid    in   1      i_data qualifier; nothing changes when low
//   i_data     in   1      received PRBS bit
//   o_locked   out  1      high while locked
//   o_err      out  1      one-cycle pulse per mismatching valid bit while locked
//   o_bit_cnt  out  CNT_W  valid bits received while locked (saturating)
//   o_err_cnt  out  CNT_W  mismatches while locked (saturating)
//
// Optional feature macro: PRBS_CHK_CLEAR_EN (adds i_clear).

module prbs_checker #(
  parameter int                  LFSR_LEN   = 15,
  parameter logic [LFSR_LEN-1:0] TAPS       = 15'h6000,
  parameter int                  LOCK_CNT   = 32,
  parameter int                  WINDOW     = 64,
  parameter int                  UNLOCK_ERR = 16,
  parameter int                  CNT_W      = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
`ifdef PRBS_CHK_CLEAR_EN
  input  logic             i_clear,
`endif
  input  logic             i_valid,
  input  logic             i_data,
  output logic             o_locked,
  output logic             o_err,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int FILL_W  = $clog2(LFSR_LEN + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WINDOW);
  localparam int WERR_W  = $clog2(WINDOW + 1);

  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(LFSR_LEN - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0]  UNLOCK_LIM = WERR_W'(UNLOCK_ERR);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state;
  logic [LFSR_LEN-1:0] sr;
  logic [FILL_W-1:0]   fill_cnt;
  logic [MATCH_W-1:0]  match_cnt;
  logic [WIN_W-1:0]    win_cnt;
  logic [WERR_W-1:0]   win_err;

  logic                pred;
  logic                mismatch;
  logic [WERR_W-1:0]   win_err_next;

  // The predicted bit comes from the received history, so a single line error
  // re-appears once for every tap it passes through.
  assign pred = ^(sr & TAPS);
  // An all-zero history would predict 0 forever; a zero bit on top of it is
  // treated as a mismatch so the checker can never lock to the dead state.
  assign mismatch     = (i_data != pred) || ((sr == '0) && !i_data);
  assign win_err_next = win_err + WERR_W'(mismatch);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= SEARCH;
      sr        <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      o_locked  <= 1'b0;
      o_err     <= 1'b0;
      o_bit_cnt <= '0;
      o_err_cnt <= '0;
    end else begin
      o_err <= 1'b0;
      if (i_valid) begin
        sr <= {sr[LFSR_LEN-2:0], i_data};
        case (state)
          SEARCH: begin
            if (fill_cnt == FILL_LAST) begin
              state     <= SYNC;
              fill_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
          SYNC: begin
            if (mismatch) begin
              match_cnt <= '0;
            end else if (match_cnt == MATCH_LAST) begin
              // The locking bit itself is not counted.
              state     <= LOCKED;
              o_locked  <= 1'b1;
              o_bit_cnt <= '0;
              o_err_cnt <= '0;
              win_cnt   <= '0;
              win_err   <= '0;
            end else begin
              match_cnt <= match_cnt + 1'b1;
            end
          end
          LOCKED: begin
            if (o_bit_cnt != '1) o_bit_cnt <= o_bit_cnt + 1'b1;
            if (mismatch) begin
              o_err <= 1'b1;
              if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
            end
            // The last bit of the window is included in the unlock decision.
            if (win_cnt == WIN_LAST) begin
              win_cnt <= '0;
              win_err <= '0;
              if (win_err_next >= UNLOCK_LIM) begin
                state    <= SEARCH;
                o_locked <= 1'b0;
                fill_cnt <= '0;
              end
            end else begin
              win_cnt <= win_cnt + 1'b1;
              win_err <= win_err_next;
            end
          end
          default: begin
            state    <= SEARCH;
            o_locked <= 1'b0;
            fill_cnt <= '0;
          end
        endcase
      end
`ifdef PRBS_CHK_CLEAR_EN
      // Placed last so that it overrides any count made on the same edge.
      if (i_clear) begin
        o_bit_cnt <= '0;
        o_err_cnt <= '0;
        o_err     <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - scoreboard and table-driven bench for prbs_checker

module tb_prbs_checker;

  localparam int          CW   = 8;
  localparam int          MAXC = (1 << CW) - 1;
  localparam logic [14:0] TAPS = 15'h6000;

  localparam int M_RESET = 0;
  localparam int M_PRBS  = 1;
  localparam int M_FLIP  = 2;
  localparam int M_RAND  = 3;
  localparam int M_ZERO  = 4;
  localparam int M_CLEAR = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic          data = 1'b0;
  logic          clear = 1'b0;
  logic          locked;
  logic          err;
  logic [CW-1:0] bc;
  logic [CW-1:0] ec;

  always #5 clk = ~clk;

  prbs_checker #(.CNT_W(CW)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
`ifdef PRBS_CHK_CLEAR_EN
    .i_clear   (clear),
`endif
    .i_valid   (valid),
    .i_data    (data),
    .o_locked  (locked),
    .o_err     (err),
    .o_bit_cnt (bc),
    .o_err_cnt (ec)
  );

  typedef struct packed {
    logic          locked;
    logic          err;
    logic [CW-1:0] bc;
    logic [CW-1:0] ec;
  } obs_t;

  typedef struct {
    string name;
    int    mode;
    int    nbits;
    bit    gap;
    int    exp_locked;  // -1 = not checked
    int    exp_bc;
    int    exp_ec;
    int    exp_pulses;
  } row_t;

  obs_t exp_q[$];
  row_t rows[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;

  logic [14:0] gen_sr = 15'h0001;

  logic [14:0] m_sr;
  int          m_state, m_fill, m_match, m_win, m_werr, m_bc, m_ec;
  logic        m_locked, m_err;

  function automatic logic gen_bit();
    logic b;
    b = ^(gen_sr & TAPS);
    gen_sr = {gen_sr[13:0], b};
    return b;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit d, input bit c);
    logic pred, mis;
    if (r) begin
      m_sr = '0; m_state = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
      m_bc = 0; m_ec = 0; m_locked = 0; m_err = 0;
      return;
    end
    m_err = 0;
    if (v) begin
      pred = ^(m_sr & TAPS);
      mis  = (d != pred) || (m_sr == 0 && d == 0);
      m_sr = {m_sr[13:0], d};
      if (m_state == 0) begin
        m_fill++;
        if (m_fill == 15) begin m_state = 1; m_match = 0; end
      end else if (m_state == 1) begin
        m_match = mis ? 0 : m_match + 1;
        if (m_match == 32) begin
          m_state = 2; m_locked = 1; m_bc = 0; m_ec = 0; m_win = 0; m_werr = 0;
        end
      end else begin
        if (m_bc < MAXC) m_bc++;
        if (mis) begin
          m_err = 1; m_werr++;
          if (m_ec < MAXC) m_ec++;
        end
        m_win++;
        if (m_win == 64) begin
          if (m_werr >= 16) begin m_state = 0; m_locked = 0; m_fill = 0; end
          m_win = 0; m_werr = 0;
        end
      end
    end
    if (c) begin m_bc = 0; m_ec = 0; m_err = 0; end
  endtask

  task automatic step(input bit r, input bit v, input bit d, input bit c);
    obs_t e, g;
    rst = r; valid = v; data = d; clear = c;
    model(r, v, d, c);
    exp_q.push_back({m_locked, m_err, CW'(m_bc), CW'(m_ec)});
    @(posedge clk);
    #1;
    g = {locked, err, bc, ec};
    e = exp_q.pop_front();
    if (err) pulses++;
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL scoreboard t=%0t got lock=%0b err=%0b bc=%0d ec=%0d want lock=%0b err=%0b bc=%0d ec=%0d",
               $time, g.locked, g.err, g.bc, g.ec, e.locked, e.err, e.bc, e.ec);
    end
  endtask

  task automatic add(input string n, input int m, input int nb, input bit gp,
                     input int l, input int b, input int e, input int p);
    row_t r;
    r.name = n; r.mode = m; r.nbits = nb; r.gap = gp;
    r.exp_locked = l; r.exp_bc = b; r.exp_ec = e; r.exp_pulses = p;
    rows.push_back(r);
  endtask

  initial begin
    int   mask;
    int   hold_bc;
    logic d;

    add("reset",         M_RESET, 1,   0,  0,    0,  0,  0);
    add("fill_46",       M_PRBS,  46,  0,  0,    0,  0,  0);
    add("lock_bit_47",   M_PRBS,  1,   0,  1,    0,  0,  0);
    add("clean_100",     M_PRBS,  100, 0,  1,  100,  0,  0);
    add("single_error",  M_FLIP,  40,  0,  1,  140,  3,  3);
    add("bit_cnt_sat",   M_PRBS,  200, 0,  1, MAXC,  3,  0);
    add("random_loss",   M_RAND,  200, 0,  0,   -1, -1, -1);
    add("relock",        M_PRBS,  47,  0,  1,   -1,  0,  0);
    add("reset_gap",     M_RESET, 1,   0,  0,    0,  0,  0);
    add("gap_46",        M_PRBS,  46,  1,  0,    0,  0,  0);
    add("gap_lock_47",   M_PRBS,  1,   1,  1,    0,  0,  0);
    add("reset_zero",    M_RESET, 1,   0,  0,    0,  0,  0);
    add("all_zero_500",  M_ZERO,  500, 0,  0,    0,  0,  0);
    add("lock_pre_rst",  M_PRBS,  47,  0,  1,   -1, -1,  0);
    add("reset_mid",     M_RESET, 2,   0,  0,    0,  0,  0);
    add("refill_46",     M_PRBS,  46,  0,  0,    0,  0,  0);
    add("relock_47",     M_PRBS,  1,   0,  1,    0,  0,  0);

    for (int i = 0; i < rows.size(); i++) begin
      pulses = 0;
      for (int k = 0; k < rows[i].nbits; k++) begin
        case (rows[i].mode)
          M_RESET: step(1, 0, 0, 0);
          M_ZERO:  step(0, 1, 0, 0);
          M_RAND:  step(0, 1, 1'($urandom_range(0, 1)), 0);
          M_FLIP: begin
            d = gen_bit();
            step(0, 1, (k == 0) ? ~d : d, 0);
          end
          default: step(0, 1, gen_bit(), 0);
        endcase
        if (rows[i].gap) step(0, 0, 1'($urandom_range(0, 1)), 0);
      end
      if (rows[i].exp_locked >= 0) check({rows[i].name, " locked"}, int'(locked), rows[i].exp_locked);
      if (rows[i].exp_bc >= 0)     check({rows[i].name, " bit_cnt"}, int'(bc), rows[i].exp_bc);
      if (rows[i].exp_ec >= 0)     check({rows[i].name, " err_cnt"}, int'(ec), rows[i].exp_ec);
      if (rows[i].exp_pulses >= 0) check({rows[i].name, " err_pulses"}, pulses, rows[i].exp_pulses);
    end

    // One flipped bit right after lock: pulses at offsets 0, 14 and 15.
    mask = 0;
    for (int k = 0; k < 20; k++) begin
      d = gen_bit();
      step(0, 1, (k == 0) ? ~d : d, 0);
      if (err) mask |= (1 << k);
    end
    check("flip_pulse_offsets", mask, (1 << 0) | (1 << 14) | (1 << 15));
    check("flip_err_cnt", int'(ec), 3);
    check("flip_locked", int'(locked), 1);

    // Idle cycles with toggling data must not move anything.
    for (int k = 0; k < 6; k++) step(0, 0, k[0], 0);
    check("idle_bit_cnt", int'(bc), 20);
    check("idle_err_cnt", int'(ec), 3);

`ifdef PRBS_CHK_CLEAR_EN
    for (int k = 0; k < 5; k++) step(0, 1, gen_bit(), 0);
    check("pre_clear_bit_cnt", int'(bc), 25);
    step(0, 1, gen_bit(), 1);
    check("clear_bit_cnt", int'(bc), 0);
    check("clear_err_cnt", int'(ec), 0);
    check("clear_locked", int'(locked), 1);
    hold_bc = 0;
    for (int k = 0; k < 3; k++) step(0, 1, gen_bit(), 0);
    check("post_clear_bit_cnt", int'(bc), hold_bc + 3);
    check("post_clear_err_cnt", int'(ec), 0);
`else
    hold_bc = 20;
    for (int k = 0; k < 3; k++) step(0, 1, gen_bit(), 0);
    check("tail_bit_cnt", int'(bc), hold_bc + 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
